// File: rtl/peripheral_ahb3_pkg.sv
// AHB3-Lite protocol constants shared by the GPIO bridge arbiter
// and any future multi-master AHB blocks.
package peripheral_ahb3_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Beats still owed after the NONSEQ of a fixed-length burst.
  function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
    logic [3:0] n;
    n = 4'd0;
    unique case (1'b1)
      (hburst == HBURST_INCR4 || hburst == HBURST_WRAP4):
        n = 4'd3;
      (hburst == HBURST_INCR8 || hburst == HBURST_WRAP8):
        n = 4'd7;
      (hburst == HBURST_INCR16 || hburst == HBURST_WRAP16):
        n = 4'd15;
      default:
        n = 4'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/peripheral_arb_rr.sv
// Combinational round-robin picker: first requester after `last`,
// wrapping around; keeps `last` when nobody else asks.
module peripheral_arb_rr
  import peripheral_ahb3_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] nxt
);

  logic [N-1:0] hi_req;

  function automatic logic [IW-1:0] lsb(input logic [N-1:0] v);
    logic [IW-1:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--)
      if (v[i]) r = IW'(i);
    return r;
  endfunction

  always_comb begin
    hi_req = '0;
    for (int i = 0; i < N; i++)
      hi_req[i] = req[i] && (i > int'(last));
    nxt = last;
    if (|hi_req)
      nxt = lsb(hi_req);
    else if (|req)
      nxt = lsb(req);
  end

endmodule

// File: rtl/peripheral_ahb3_arbiter.sv
// Round-robin AHB3-Lite arbiter sharing the GPIO bridge slave port;
// holds ownership over bursts and locked sequences.
module peripheral_ahb3_arbiter
  import peripheral_ahb3_pkg::*;
#(
  parameter int MASTERS    = 3,
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESET,

  input  logic [MASTERS-1:0]    mst_HSEL,
  input  logic [HADDR_SIZE-1:0] mst_HADDR     [MASTERS],
  input  logic [HDATA_SIZE-1:0] mst_HWDATA    [MASTERS],
  input  logic [MASTERS-1:0]    mst_HWRITE,
  input  logic [2:0]            mst_HSIZE     [MASTERS],
  input  logic [2:0]            mst_HBURST    [MASTERS],
  input  logic [3:0]            mst_HPROT     [MASTERS],
  input  logic [1:0]            mst_HTRANS    [MASTERS],
  input  logic [MASTERS-1:0]    mst_HMASTLOCK,
  output logic [HDATA_SIZE-1:0] mst_HRDATA    [MASTERS],
  output logic [MASTERS-1:0]    mst_HREADY,
  output logic [MASTERS-1:0]    mst_HRESP,

  output logic                  slv_HSEL,
  output logic [HADDR_SIZE-1:0] slv_HADDR,
  output logic [HDATA_SIZE-1:0] slv_HWDATA,
  output logic                  slv_HWRITE,
  output logic [2:0]            slv_HSIZE,
  output logic [2:0]            slv_HBURST,
  output logic [3:0]            slv_HPROT,
  output logic [1:0]            slv_HTRANS,
  output logic                  slv_HMASTLOCK,
  output logic                  slv_HREADY,
  input  logic                  slv_HREADYOUT,
  input  logic                  slv_HRESP,
  input  logic [HDATA_SIZE-1:0] slv_HRDATA
);

  localparam int GW = $clog2(MASTERS);

  logic [GW-1:0]      gnt;
  logic [GW-1:0]      dph_own;
  logic               dph_vld;
  logic [3:0]         beat_cnt;
  logic               incr_hold;

  logic [MASTERS-1:0] req;
  logic [1:0]         g_trans;
  logic [3:0]         beat_nxt;
  logic               incr_nxt;
  logic               hold;
  logic [GW-1:0]      rr_nxt;
  logic [GW-1:0]      gnt_nxt;

  always_comb begin
    req = '0;
    for (int i = 0; i < MASTERS; i++)
      req[i] = mst_HSEL[i] & mst_HTRANS[i][1];
  end

  // An unselected owner is treated as idle on this port.
  assign g_trans = mst_HSEL[gnt] ? mst_HTRANS[gnt] : HTRANS_IDLE;

  always_comb begin
    beat_nxt = beat_cnt;
    incr_nxt = incr_hold;
    unique case (1'b1)
      (g_trans == HTRANS_IDLE): begin
        beat_nxt = 4'd0;
        incr_nxt = 1'b0;
      end
      (g_trans == HTRANS_NONSEQ): begin
        beat_nxt = burst_beats(mst_HBURST[gnt]);
        incr_nxt = (mst_HBURST[gnt] == HBURST_INCR);
      end
      (g_trans == HTRANS_SEQ): begin
        if (beat_cnt != 4'd0)
          beat_nxt = beat_cnt - 4'd1;
      end
      default: begin
        beat_nxt = beat_cnt;
        incr_nxt = incr_hold;
      end
    endcase
  end

  assign hold = (beat_nxt != 4'd0)
              | incr_nxt
              | mst_HMASTLOCK[gnt];

  peripheral_arb_rr #(
    .N  (MASTERS),
    .IW (GW)
  ) u_rr (
    .req  (req),
    .last (gnt),
    .nxt  (rr_nxt)
  );

  assign gnt_nxt = hold ? gnt : rr_nxt;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      gnt       <= '0;
      dph_own   <= '0;
      dph_vld   <= 1'b0;
      beat_cnt  <= 4'd0;
      incr_hold <= 1'b0;
    end else if (slv_HREADYOUT) begin
      gnt       <= gnt_nxt;
      dph_own   <= gnt;
      dph_vld   <= req[gnt];
      beat_cnt  <= beat_nxt;
      incr_hold <= incr_nxt;
    end
  end

  assign slv_HSEL      = mst_HSEL[gnt];
  assign slv_HADDR     = mst_HADDR[gnt];
  assign slv_HWRITE    = mst_HWRITE[gnt];
  assign slv_HSIZE     = mst_HSIZE[gnt];
  assign slv_HBURST    = mst_HBURST[gnt];
  assign slv_HPROT     = mst_HPROT[gnt];
  assign slv_HTRANS    = mst_HTRANS[gnt];
  assign slv_HMASTLOCK = mst_HMASTLOCK[gnt];
  assign slv_HWDATA    = mst_HWDATA[dph_own];
  assign slv_HREADY    = slv_HREADYOUT;

  // Waiting requesters are stalled; bystanders see a ready bus.
  always_comb begin
    for (int i = 0; i < MASTERS; i++) begin
      if (dph_vld && dph_own == GW'(i)) begin
        mst_HRDATA[i] = slv_HRDATA;
        mst_HRESP[i]  = slv_HRESP;
      end else begin
        mst_HRDATA[i] = '0;
        mst_HRESP[i]  = HRESP_OKAY;
      end
      if (gnt == GW'(i) || (dph_vld && dph_own == GW'(i)))
        mst_HREADY[i] = slv_HREADYOUT;
      else
        mst_HREADY[i] = ~req[i];
    end
  end

endmodule

// File: tb/tb_peripheral_ahb3_arbiter.sv
// Bench for peripheral_ahb3_arbiter: directed scenarios plus random
// traffic, every cycle checked against an ownership-level model.
module tb_peripheral_ahb3_arbiter;

  localparam int M = 3;

  logic        HCLK = 1'b0;
  logic        rst;
  logic [M-1:0] hsel;
  logic [31:0] haddr  [M];
  logic [31:0] hwdata [M];
  logic [M-1:0] hwrite;
  logic [2:0]  hsize  [M];
  logic [2:0]  hburst [M];
  logic [3:0]  hprot  [M];
  logic [1:0]  htrans [M];
  logic [M-1:0] hlock;
  logic [31:0] o_rdata [M];
  logic [M-1:0] o_rdy;
  logic [M-1:0] o_resp;
  logic        s_sel, s_write, s_lock, s_rdy;
  logic [31:0] s_addr, s_wdata;
  logic [2:0]  s_size, s_burst;
  logic [3:0]  s_prot;
  logic [1:0]  s_trans;
  logic        hro, hresp;
  logic [31:0] hrdata;

  int n_cmp = 0;
  int n_err = 0;

  // reference model: who owns what, and how much of the burst is left
  int m_gnt, m_own, m_left;
  bit m_vld, m_incr;

  always #5 HCLK = ~HCLK;

  peripheral_ahb3_arbiter #(
    .MASTERS(M), .HADDR_SIZE(32), .HDATA_SIZE(32)
  ) dut (
    .HCLK(HCLK), .HRESET(rst),
    .mst_HSEL(hsel), .mst_HADDR(haddr), .mst_HWDATA(hwdata),
    .mst_HWRITE(hwrite), .mst_HSIZE(hsize), .mst_HBURST(hburst),
    .mst_HPROT(hprot), .mst_HTRANS(htrans), .mst_HMASTLOCK(hlock),
    .mst_HRDATA(o_rdata), .mst_HREADY(o_rdy), .mst_HRESP(o_resp),
    .slv_HSEL(s_sel), .slv_HADDR(s_addr), .slv_HWDATA(s_wdata),
    .slv_HWRITE(s_write), .slv_HSIZE(s_size), .slv_HBURST(s_burst),
    .slv_HPROT(s_prot), .slv_HTRANS(s_trans), .slv_HMASTLOCK(s_lock),
    .slv_HREADY(s_rdy), .slv_HREADYOUT(hro), .slv_HRESP(hresp),
    .slv_HRDATA(hrdata)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
               $time);
    end
  endtask

  function automatic bit mreq(input int i);
    return hsel[i] && htrans[i][1];
  endfunction

  function automatic int burst_len(input int b);
    case (b)
      0: return 1;
      2, 3: return 4;
      4, 5: return 8;
      6, 7: return 16;
      default: return 0;
    endcase
  endfunction

  task automatic model_update();
    int g, t, b, n;
    if (rst) begin
      m_gnt = 0; m_own = 0; m_vld = 0; m_left = 0; m_incr = 0;
      return;
    end
    if (!hro) return;
    g = m_gnt;
    t = hsel[g] ? int'(htrans[g]) : 0;
    b = int'(hburst[g]);
    m_own = g;
    m_vld = mreq(g);
    if (t == 0) begin
      m_left = 0; m_incr = 0;
    end else if (t == 2) begin
      n = burst_len(b);
      m_left = (n > 1) ? n - 1 : 0;
      m_incr = (b == 1);
    end else if (t == 3 && m_left > 0) begin
      m_left--;
    end
    if (m_left == 0 && !m_incr && !hlock[g])
      for (int k = 1; k <= M; k++)
        if (mreq((g + k) % M)) begin
          m_gnt = (g + k) % M;
          break;
        end
  endtask

  task automatic check_outputs();
    logic [M-1:0] e_rdy, e_resp;
    bit own;
    int g;
    g = m_gnt;
    chk("slv_haddr", s_addr, haddr[g]);
    chk("slv_ctrl",
        {s_sel, s_write, s_size, s_burst, s_prot, s_trans, s_lock},
        {hsel[g], hwrite[g], hsize[g], hburst[g], hprot[g],
         htrans[g], hlock[g]});
    chk("slv_hwdata", s_wdata, hwdata[m_own]);
    chk("slv_hready", s_rdy, hro);
    for (int i = 0; i < M; i++) begin
      own = m_vld && (m_own == i);
      e_rdy[i]  = (i == g || own) ? hro : !mreq(i);
      e_resp[i] = own ? hresp : 1'b0;
      chk("mst_hrdata", o_rdata[i], own ? hrdata : 32'h0);
    end
    chk("mst_hready", o_rdy, e_rdy);
    chk("mst_hresp", o_resp, e_resp);
  endtask

  task automatic half();
    @(negedge HCLK);
    check_outputs();
  endtask

  task automatic edge_();
    @(posedge HCLK);
    model_update();
    #1;
  endtask

  task automatic tick();
    half();
    edge_();
  endtask

  task automatic idle(input int i);
    hsel[i] = 1'b0; htrans[i] = 2'd0; hburst[i] = 3'd0;
    hlock[i] = 1'b0; hwrite[i] = 1'b0;
  endtask

  task automatic drv(input int i, input logic [1:0] t,
                     input logic [2:0] b, input logic [31:0] a,
                     input logic w, input logic l);
    hsel[i] = 1'b1; htrans[i] = t; hburst[i] = b; haddr[i] = a;
    hwrite[i] = w; hlock[i] = l; hsize[i] = 3'd2; hprot[i] = 4'h3;
  endtask

  initial begin
    rst = 1'b1; hro = 1'b1; hresp = 1'b0; hrdata = 32'h1234_5678;
    for (int i = 0; i < M; i++) begin
      idle(i);
      haddr[i] = 32'h0; hsize[i] = 3'd0; hprot[i] = 4'h0;
      hwdata[i] = 32'hD000_0000 + 32'(i);
    end
    edge_();
    edge_();
    rst = 1'b0;

    // reset and idle
    half();
    chk("rst_hready", o_rdy, 3'b111);
    chk("rst_htrans", s_trans, 2'd0);
    edge_();

    // single-transfer contention
    drv(0, 2'd2, 3'd0, 32'h10, 1'b1, 1'b0);
    drv(1, 2'd2, 3'd0, 32'h20, 1'b1, 1'b0);
    half();
    chk("c2_addr0", s_addr, 32'h10);
    chk("c2_m1_wait", o_rdy[1], 1'b0);
    edge_();
    idle(0);
    half();
    chk("c2_addr1", s_addr, 32'h20);
    chk("c2_wdata0", s_wdata, 32'hD000_0000);
    chk("c2_m1_go", o_rdy[1], 1'b1);
    edge_();
    idle(1);
    half();
    chk("c2_wdata1", s_wdata, 32'hD000_0001);
    edge_();

    // INCR4 with a BUSY, master 0 waiting
    drv(2, 2'd2, 3'd3, 32'h100, 1'b1, 1'b0);
    drv(0, 2'd2, 3'd0, 32'h0, 1'b0, 1'b0);
    tick();
    half();
    chk("c3_nonseq", s_addr, 32'h100);
    edge_();
    drv(2, 2'd3, 3'd3, 32'h104, 1'b1, 1'b0);
    tick();
    drv(2, 2'd1, 3'd3, 32'h108, 1'b1, 1'b0);
    half();
    chk("c3_busy_hold", o_rdy[0], 1'b0);
    edge_();
    drv(2, 2'd3, 3'd3, 32'h108, 1'b1, 1'b0);
    tick();
    drv(2, 2'd3, 3'd3, 32'h10C, 1'b1, 1'b0);
    half();
    chk("c3_last_wait", o_rdy[0], 1'b0);
    edge_();
    idle(2);
    half();
    chk("c3_m0_gnt", s_addr, 32'h0);
    chk("c3_m0_rdy", o_rdy[0], 1'b1);
    edge_();
    idle(0);
    tick();

    // undefined-length INCR of 6 beats ending in IDLE
    drv(1, 2'd2, 3'd1, 32'h200, 1'b1, 1'b0);
    drv(2, 2'd2, 3'd0, 32'h300, 1'b0, 1'b0);
    tick();
    tick();
    for (int k = 1; k <= 5; k++) begin
      drv(1, 2'd3, 3'd1, 32'h200 + 32'(4 * k), 1'b1, 1'b0);
      half();
      chk("c4_incr_hold", o_rdy[2], 1'b0);
      edge_();
    end
    drv(1, 2'd0, 3'd1, 32'h214, 1'b1, 1'b0);
    half();
    chk("c4_idle", s_trans, 2'd0);
    edge_();
    idle(1);
    half();
    chk("c4_m2", s_addr, 32'h300);
    edge_();
    idle(2);
    tick();

    // locked pair of SINGLEs
    drv(0, 2'd2, 3'd0, 32'h400, 1'b1, 1'b1);
    drv(1, 2'd2, 3'd0, 32'h500, 1'b1, 1'b0);
    tick();
    half();
    chk("c4_lock_a", s_addr, 32'h400);
    edge_();
    drv(0, 2'd2, 3'd0, 32'h404, 1'b1, 1'b1);
    half();
    chk("c4_lock_b", s_addr, 32'h404);
    chk("c4_lock_m1", o_rdy[1], 1'b0);
    edge_();
    drv(0, 2'd0, 3'd0, 32'h404, 1'b0, 1'b0);
    tick();
    idle(0);
    half();
    chk("c4_m1", s_addr, 32'h500);
    edge_();
    idle(1);
    tick();

    // two-cycle ERROR on a master 0 read
    drv(0, 2'd2, 3'd0, 32'h40, 1'b0, 1'b0);
    tick();
    half();
    chk("c5_addr", s_addr, 32'h40);
    edge_();
    idle(0);
    drv(1, 2'd2, 3'd0, 32'h600, 1'b0, 1'b0);
    hro = 1'b0; hresp = 1'b1;
    half();
    chk("c5_resp1", o_resp[0], 1'b1);
    chk("c5_rdy1", o_rdy[0], 1'b0);
    chk("c5_m1_wait1", o_rdy[1], 1'b0);
    edge_();
    hro = 1'b1;
    half();
    chk("c5_resp2", o_resp[0], 1'b1);
    chk("c5_rdy2", o_rdy[0], 1'b1);
    chk("c5_m1_wait2", o_rdy[1], 1'b0);
    edge_();
    hresp = 1'b0;
    half();
    chk("c5_m1", s_addr, 32'h600);
    chk("c5_m1_rdy", o_rdy[1], 1'b1);
    edge_();
    idle(1);
    tick();

    // reset in the middle of an INCR8
    haddr[0] = 32'h0000_AAA0;
    drv(2, 2'd2, 3'd5, 32'h800, 1'b0, 1'b0);
    tick();
    tick();
    drv(2, 2'd3, 3'd5, 32'h804, 1'b0, 1'b0);
    tick();
    drv(2, 2'd3, 3'd5, 32'h808, 1'b0, 1'b0);
    rst = 1'b1;
    hrdata = 32'hDEAD_BEEF;
    tick();
    rst = 1'b0;
    drv(2, 2'd3, 3'd5, 32'h80C, 1'b0, 1'b0);
    half();
    chk("c6_rst_addr", s_addr, 32'h0000_AAA0);
    chk("c6_rst_rdata", o_rdata[2], 32'h0);
    chk("c6_rst_m2wait", o_rdy[2], 1'b0);
    chk("c6_rst_m0rdy", o_rdy[0], 1'b1);
    edge_();
    idle(2);
    tick();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < M; i++) begin
        hsel[i]   = ($urandom_range(0, 7) != 0);
        htrans[i] = 2'($urandom_range(0, 3));
        hburst[i] = 3'($urandom_range(0, 7));
        haddr[i]  = $urandom;
        hwdata[i] = $urandom;
        hwrite[i] = 1'($urandom_range(0, 1));
        hsize[i]  = 3'($urandom_range(0, 7));
        hprot[i]  = 4'($urandom_range(0, 15));
        hlock[i]  = ($urandom_range(0, 7) == 0);
      end
      hro    = ($urandom_range(0, 3) != 0);
      hresp  = ($urandom_range(0, 7) == 0);
      hrdata = $urandom;
      rst    = ($urandom_range(0, 149) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/peripheral_ahb3_arbiter.md
# peripheral_ahb3_arbiter

Multi-master AHB3-Lite arbiter that shares the single AHB slave port of the GPIO bridge (AHB-to-APB) between `MASTERS` AHB-Lite masters. It sits between the masters and the bridge slave interface. It grants the slave address phase round-robin, keeps ownership across fixed/undefined-length bursts and locked sequences, and routes data-phase signals back to the right master. There are no dead cycles on ownership handover.

## Interface
- `MASTERS`, 3: number of masters (2..8).
- `HADDR_SIZE`, 32: address width.
- `HDATA_SIZE`, 32: data width.
- `HCLK` in 1: single clock.
- `HRESET` in 1: reset, synchronous, active-high.
- `mst_HSEL` in [MASTERS]: per-master select.
- `mst_HADDR` in [MASTERS][HADDR_SIZE]: per-master address.
- `mst_HWDATA` in [MASTERS][HDATA_SIZE]: per-master write data.
- `mst_HWRITE` in [MASTERS]: per-master write.
- `mst_HSIZE` in [MASTERS][3]: per-master size.
- `mst_HBURST` in [MASTERS][3]: per-master burst type.
- `mst_HPROT` in [MASTERS][4]: per-master protection.
- `mst_HTRANS` in [MASTERS][2]: per-master transfer type.
- `mst_HMASTLOCK` in [MASTERS]: per-master lock.
- `mst_HRDATA` out [MASTERS][HDATA_SIZE]: read data to each master.
- `mst_HREADY` out [MASTERS]: ready to each master.
- `mst_HRESP` out [MASTERS]: response to each master.
- `slv_HSEL`, `slv_HADDR`, `slv_HWDATA`, `slv_HWRITE`, `slv_HSIZE`, `slv_HBURST`, `slv_HPROT`, `slv_HTRANS`, `slv_HMASTLOCK` out: muxed slave request.
- `slv_HREADY` out 1: slave HREADY input, equal to `slv_HREADYOUT`.
- `slv_HREADYOUT` in 1: slave ready.
- `slv_HRESP` in 1: slave response.
- `slv_HRDATA` in HDATA_SIZE: slave read data.

## Operation
- **Request:** `req[i] = mst_HSEL[i] & mst_HTRANS[i][1]` (NONSEQ/SEQ).
- **Registers:**
  - `gnt` (index): address-phase owner.
  - `dph_own` (index) and `dph_vld`: data-phase owner.
  - `beat_cnt` (4 bit).
  - `incr_hold`.
- **Address mux:** all `slv_*` request signals come from master `gnt`.
- **Data mux:** `slv_HWDATA` comes from `dph_own`.
- **Data-phase advance:** on an edge with `slv_HREADYOUT=1`:
  - `dph_own <= gnt`.
  - `dph_vld <= req[gnt]`.
- **Hold** (no re-arbitration) while any of the following is true:
  - `beat_cnt != 0`.
  - `incr_hold = 1`.
  - `mst_HMASTLOCK[gnt] = 1`.
- **Burst tracking** (only on edges with `slv_HREADYOUT=1` and `req[gnt]`):
  - Accepted NONSEQ with INCR4/WRAP4 loads `beat_cnt = 3`; INCR8/WRAP8 loads 7; INCR16/WRAP16 loads 15.
  - Accepted NONSEQ with INCR sets `incr_hold`.
  - Accepted SEQ decrements `beat_cnt` if it is non-zero.
- **`incr_hold` clear:** when `gnt` presents IDLE or NONSEQ while `slv_HREADYOUT=1`. The NONSEQ itself is still issued by the current owner.
- **BUSY:** holds ownership and does not change `beat_cnt`.
- **Re-arbitration:** on an edge with `slv_HREADYOUT=1` where none of the hold conditions holds after this cycle's update:
  - Next `gnt` = first requesting master after `gnt`, in circular order.
  - If none other requests, `gnt` stays (parking).
- **Master responses:**
  - `dph_own` (when `dph_vld`) receives `slv_HRDATA`, `slv_HRESP` and `slv_HREADYOUT`.
  - `gnt` receives `mst_HREADY = slv_HREADYOUT`.
  - Any other master with `req=1` receives `mst_HREADY=0` (address held off).
  - Any other master with `req=0` receives `mst_HREADY=1`.
  - All masters other than the data-phase owner see `HRESP = OKAY` and `HRDATA = 0`.
- **ERROR:** the two-cycle ERROR passes through unchanged. No re-arbitration happens in the first cycle, because `HREADYOUT=0`. If the owner cancels with IDLE in the second cycle, `incr_hold` and `beat_cnt` are cleared.

## Timing
- **Reset values:**
  - Registers: `gnt=0`, `dph_vld=0`, `beat_cnt=0`, `incr_hold=0`.
  - Outputs: `slv_*` follow master 0; `mst_HREADY` all 1 (master 0 tracks `slv_HREADYOUT`); `mst_HRESP` all OKAY; `mst_HRDATA` all 0.
- **Grant latency:** a request while the bus is free (parked on another idle master) is granted at the next edge. Its address is on the slave one cycle later, with zero dead cycles between owners.
- **Fairness:** a waiting master is granted within (MASTERS−1) ownership periods.
- **Simultaneous events:** new requests and the owner's last beat in the same cycle cause a switch on that edge.
- **Wait states:** `slv_HREADYOUT=0` freezes all registers.
- **Reset mid-burst:** all state returns to reset values on the next edge. Slave outputs then follow master 0.
- All outputs are combinational from registers and inputs. There is no combinational path from `mst_*` to `gnt`.

## Structure
- `peripheral_ahb3_pkg` holds HTRANS_*, HBURST_*, HRESP_* constants and a `burst_beats(hburst)` function.
- Sub-module `peripheral_arb_rr`: a combinational round-robin picker (request vector plus last index in, next index out). It is reused by future multi-requester blocks.

## Test plan
- **Reset and idle:** reset, all idle → `mst_HREADY=3'b111`, `slv_HTRANS=IDLE`, `gnt=0`.
- **Single-transfer contention:** masters 0 and 1 each issue NONSEQ SINGLE writes to 0x10/0x20 in the same cycle → slave sees 0x10 then 0x20 back-to-back. Master 1 sees `HREADY=0` for exactly one cycle. `HWDATA` routes correctly.
- **Fixed burst:** master 2 issues INCR4 while master 0 requests → master 2 keeps ownership for 4 beats, including one BUSY. Master 0 is granted on the edge after beat 4.
- **Undefined burst and lock:**
  - Master 1 INCR of 6 beats ends in IDLE → no switch until IDLE.
  - `HMASTLOCK=1` across two SINGLEs → no interleave.
- **Slave ERROR:** slave ERROR on master 0 read, master 1 pending → master 0 sees HRESP=1 for 2 cycles (HREADY 0 then 1). Master 1 is granted after the second cycle.
- **Reset mid-burst:** `HRESET` asserted mid-INCR8 → next cycle `beat_cnt=0`, `gnt=0`, `dph_vld=0`.
